stream_delay_buffered: RTL

- Parametrised successor to the single-beat stream delayer.
- Inserts a per-beat delay into a valid/ready stream. Beats are buffered in a Depth-entry in-order queue, so several beats can be in flight at once.
- Each beat's delay is chosen at acceptance from one of three sources: fixed, pseudo-random or runtime-programmable.
- Used in testbenches and interconnect stress paths to model latency without serialising traffic.

---
 rtl/stream_delay_buffered_pkg.sv | 21 ++
 rtl/stream_delay_buffered_rng.sv | 40 ++++
 rtl/stream_delay_buffered.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/stream_delay_buffered_pkg.sv
// stream_delay_pkg: shared types and constants for the buffered stream delayer.
//   delay_mode_e : selects where each beat's delay comes from.
//   LfsrPoly     : Galois tap mask for x^16+x^14+x^13+x^11+1.
//   DefaultSeed  : default reset/clear value of the LFSR (must be non-zero).
//   lfsr_step    : one right-shifting Galois LFSR step.
package stream_delay_pkg;

    typedef enum logic [1:0] {
        DelayFixed,
        DelayRandom,
        DelayProg
    } delay_mode_e;

    localparam logic [15:0] LfsrPoly    = 16'hB400;
    localparam logic [15:0] DefaultSeed = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] state);
        return state[0] ? ((state >> 1) ^ LfsrPoly) : (state >> 1);
    endfunction

endpackage

// File: rtl/stream_delay_buffered_rng.sv
// stream_delay_rng: 16-bit Galois LFSR used as the pseudo-random delay source.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - synchronous active-high reset, loads Seed
//   clr_i  - synchronous clear, same effect as rst_i
//   en_i   - advance one step this cycle
//   q_o    - current LFSR state
module stream_delay_rng
    import stream_delay_pkg::*;
#(
    parameter logic [15:0] Seed = DefaultSeed
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        en_i,
    output logic [15:0] q_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            lfsr_q <= Seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q_o = lfsr_q;

endmodule

// File: rtl/stream_delay_buffered.sv
// stream_delay_buffered: valid/ready stream delayer with a Depth-entry in-order
// buffer. Each accepted beat gets its own delay (fixed, LFSR or delay_i) and is
// presented once its countdown expires and it has reached the head.
// Ports:
//   clk_i          - clock, rising edge
//   rst_i          - synchronous active-high reset
//   clr_i          - synchronous clear, same effect as rst_i
//   delay_i        - per-beat delay, used only in DelayProg mode
//   payload_i      - upstream data
//   valid_i        - upstream valid
//   ready_o        - upstream ready (buffer not full)
//   payload_o      - head entry data
//   valid_o        - head entry present and its countdown expired
//   ready_i        - downstream ready
//   occupancy_o    - number of entries held
//   beats_o        - pop count        (only with STREAM_DELAY_BUFFERED_STATS_EN)
//   stall_cycles_o - valid && !ready  (only with STREAM_DELAY_BUFFERED_STATS_EN)
module stream_delay_buffered
    import stream_delay_pkg::*;
#(
    parameter type         payload_t  = logic [31:0],
    parameter int unsigned Depth      = 4,
    parameter int unsigned DelayWidth = 4,
    parameter delay_mode_e Mode       = DelayFixed,
    parameter int unsigned FixedDelay = 1,
    parameter logic [15:0] LfsrSeed   = DefaultSeed,
    localparam int unsigned AddrW     = $clog2(Depth),
    localparam int unsigned OccW      = AddrW + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic [DelayWidth-1:0] delay_i,
    input  payload_t              payload_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output payload_t              payload_o,
    output logic                  valid_o,
    input  logic                  ready_i,
`ifdef STREAM_DELAY_BUFFERED_STATS_EN
    output logic [31:0]           beats_o,
    output logic [31:0]           stall_cycles_o,
`endif
    output logic [OccW-1:0]       occupancy_o
);

    payload_t              payload_q [Depth];
    payload_t              payload_d [Depth];
    logic [DelayWidth-1:0] cnt_q     [Depth];
    logic [DelayWidth-1:0] cnt_d     [Depth];
    logic [AddrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [OccW-1:0]       occ_q,    occ_d;

    logic                  push;
    logic                  pop;
    logic [DelayWidth-1:0] delay_sel;
    logic [DelayWidth-1:0] cnt_init;
    logic [15:0]           lfsr_q;
    logic                  lfsr_unused;

    // Upper LFSR bits are deliberately not used as delay.
    assign lfsr_unused = ^lfsr_q;

    // ready_o depends only on registered occupancy: no ready_i -> ready_o path.
    assign ready_o     = (occ_q < OccW'(Depth));
    assign valid_o     = (occ_q != '0) && (cnt_q[rd_ptr_q] == '0);
    assign payload_o   = payload_q[rd_ptr_q];
    assign occupancy_o = occ_q;
    assign push        = valid_i && ready_o;
    assign pop         = valid_o && ready_i;

    if (Mode == DelayRandom) begin : g_rng
        stream_delay_rng #(
            .Seed (LfsrSeed)
        ) u_rng (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (clr_i),
            .en_i  (push),
            .q_o   (lfsr_q)
        );
    end else begin : g_no_rng
        assign lfsr_q = '0;
    end

    always_comb begin
        case (Mode)
            DelayRandom: delay_sel = lfsr_q[DelayWidth-1:0];
            DelayProg:   delay_sel = delay_i;
            default:     delay_sel = DelayWidth'(FixedDelay);
        endcase
    end

    // Countdown is loaded with D-1 so the beat is presentable D cycles later;
    // D=0 behaves as D=1 (minimum latency of one cycle).
    assign cnt_init = (delay_sel == '0) ? '0 : delay_sel - DelayWidth'(1);

    always_comb begin
        payload_d = payload_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;

        // Every entry counts down every cycle, head or not; stale slots
        // count too, which is harmless since they are reloaded on push.
        for (int unsigned i = 0; i < Depth; i++) begin
            cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - DelayWidth'(1) : '0;
        end

        if (push) begin
            payload_d[wr_ptr_q] = payload_i;
            cnt_d[wr_ptr_q]     = cnt_init;
            wr_ptr_d            = wr_ptr_q + AddrW'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + AddrW'(1);
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + OccW'(1);
            2'b01:   occ_d = occ_q - OccW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload storage needs no reset; it is only observed while valid_o=1.
    always_ff @(posedge clk_i) begin
        payload_q <= payload_d;
    end

`ifdef STREAM_DELAY_BUFFERED_STATS_EN
    logic [31:0] beats_q, beats_d;
    logic [31:0] stall_q, stall_d;

    always_comb begin
        beats_d = beats_q;
        stall_d = stall_q;
        if (pop) begin
            beats_d = beats_q + 32'd1;
        end
        if (valid_o && !ready_i) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            beats_q <= '0;
            stall_q <= '0;
        end else begin
            beats_q <= beats_d;
            stall_q <= stall_d;
        end
    end

    assign beats_o        = beats_q;
    assign stall_cycles_o = stall_q;
`endif

endmodule
